// File: rtl/net_pkg.sv
// Shared networking types: arbiter FSM states and the user-datapath beat type.
package net_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    FWD   = 2'd1,
    DRAIN = 2'd2
  } arb_state_t;

  localparam int NET_DATA_WIDTH = 64;

  typedef logic [NET_DATA_WIDTH-1:0] net_beat_t;

endpackage

// File: rtl/tx_packet_arbiter_rr_pick.sv
// Rotating-priority pick: the lowest-index request at or above i_ptr wins,
// wrapping to the lowest request overall. Uses a double-width vector whose
// low half has the requests below i_ptr masked off, so one priority encoder
// handles the wrap.
module rr_pick #(
  parameter int N     = 4,
  parameter int IDX_W = $clog2(N)
) (
  input  logic [N-1:0]     i_req,
  input  logic [IDX_W-1:0] i_ptr,
  output logic             o_any,
  output logic [IDX_W-1:0] o_grant
);

  logic [N-1:0]   w_lo_mask;
  logic [2*N-1:0] w_dbl;

  assign w_lo_mask = {N{1'b1}} << i_ptr;
  assign w_dbl     = {i_req, i_req & w_lo_mask};
  assign o_any     = |i_req;

  // Priority encode the doubled vector; scanning downward leaves the lowest set bit.
  always_comb begin
    o_grant = '0;
    for (int j = 2*N-1; j >= 0; j--) begin
      if (w_dbl[j]) begin
        o_grant = (j >= N) ? IDX_W'(j - N) : IDX_W'(j);
      end
    end
  end

endmodule

// File: rtl/tx_packet_arbiter.sv
// Packet-granular round-robin arbiter sharing one transmit user interface
// among N_PORTS sources. Enforces a maximum packet length (truncate, then
// drain the remainder), flushes orphan non-SOP beats while idle, and keeps
// status counters/flags for the management block.
module tx_packet_arbiter
  import net_pkg::*;
#(
  parameter  int N_PORTS    = 4,
  parameter  int DATA_WIDTH = NET_DATA_WIDTH,
  parameter  int MAX_BEATS  = 1200,
  localparam int IDX_W      = $clog2(N_PORTS)
) (
  input  logic                          clk,
  input  logic                          rst_n,
  input  logic [N_PORTS-1:0]            port_en,
  input  logic [N_PORTS-1:0]            s_valid,
  input  logic [N_PORTS*DATA_WIDTH-1:0] s_data,
  input  logic [N_PORTS-1:0]            s_sop,
  input  logic [N_PORTS-1:0]            s_eop,
  output logic [N_PORTS-1:0]            s_ready,
  output logic                          m_valid,
  output logic [DATA_WIDTH-1:0]         m_data,
  output logic                          m_sop,
  output logic                          m_eop,
  input  logic                          m_ready,
  output logic                          busy,
  output logic [IDX_W-1:0]              cur_grant,
  output logic [15:0]                   pkt_count,
  output logic                          err_len,
  output logic                          err_frame
);

  arb_state_t r_state, w_state_nxt;

  logic [IDX_W-1:0] r_rr_ptr, w_rr_ptr_nxt;
  logic [IDX_W-1:0] r_grant, w_grant_nxt;
  logic [15:0]      r_beat_cnt, w_beat_cnt_nxt;
  logic [15:0]      r_pkt_count, w_pkt_count_nxt;
  logic             r_err_len, w_err_len_nxt;
  logic             r_err_frame, w_err_frame_nxt;

  logic [N_PORTS-1:0]    w_eligible;
  logic [N_PORTS-1:0]    w_orphan;
  logic                  w_any;
  logic [IDX_W-1:0]      w_pick;
  logic                  w_g_valid;
  logic [DATA_WIDTH-1:0] w_g_data;
  logic                  w_g_sop;
  logic                  w_g_eop;
  logic                  w_at_limit;
  logic [IDX_W-1:0]      w_grant_inc;

  assign w_eligible = port_en & s_valid & s_sop;
  // Orphan beats (valid without SOP while idle) are accepted only to be discarded.
  assign w_orphan   = port_en & s_valid & ~s_sop;

  assign w_g_valid  = s_valid[r_grant];
  assign w_g_data   = s_data[r_grant*DATA_WIDTH +: DATA_WIDTH];
  assign w_g_sop    = s_sop[r_grant];
  assign w_g_eop    = s_eop[r_grant];

  // beat_cnt counts beats already accepted, so this is the last allowed beat.
  assign w_at_limit  = (r_beat_cnt == 16'(MAX_BEATS - 1));
  assign w_grant_inc = (r_grant == IDX_W'(N_PORTS - 1)) ? '0 : r_grant + 1'b1;

  rr_pick #(
    .N     (N_PORTS),
    .IDX_W (IDX_W)
  ) u_rr_pick (
    .i_req   (w_eligible),
    .i_ptr   (r_rr_ptr),
    .o_any   (w_any),
    .o_grant (w_pick)
  );

  // Next-state, next-register and combinational output decode.
  always_comb begin
    // NOTE: every output of this block gets a default first, so no path can infer a latch.
    w_state_nxt     = r_state;
    w_rr_ptr_nxt    = r_rr_ptr;
    w_grant_nxt     = r_grant;
    w_beat_cnt_nxt  = r_beat_cnt;
    w_pkt_count_nxt = r_pkt_count;
    w_err_len_nxt   = r_err_len;
    w_err_frame_nxt = r_err_frame;
    m_valid         = 1'b0;
    m_data          = '0;
    m_sop           = 1'b0;
    m_eop           = 1'b0;
    s_ready         = '0;

    case (r_state)
      IDLE: begin
        s_ready = w_orphan;
        if (|w_orphan) begin
          w_err_frame_nxt = 1'b1;
        end
        if (w_any) begin
          w_grant_nxt    = w_pick;
          w_beat_cnt_nxt = '0;
          w_state_nxt    = FWD;
        end
      end

      FWD: begin
        m_valid          = w_g_valid;
        m_data           = w_g_data;
        m_sop            = w_g_sop;
        m_eop            = w_g_eop | w_at_limit;
        s_ready[r_grant] = m_ready;
        if (w_g_valid && m_ready) begin
          w_beat_cnt_nxt = r_beat_cnt + 16'd1;
          if (w_g_eop) begin
            w_pkt_count_nxt = r_pkt_count + 16'd1;
            w_rr_ptr_nxt    = w_grant_inc;
            w_state_nxt     = IDLE;
          end else if (w_at_limit) begin
            w_pkt_count_nxt = r_pkt_count + 16'd1;
            w_err_len_nxt   = 1'b1;
            w_rr_ptr_nxt    = w_grant_inc;
            w_state_nxt     = DRAIN;
          end
        end
      end

      DRAIN: begin
        s_ready[r_grant] = 1'b1;
        if (w_g_valid && w_g_eop) begin
          w_state_nxt = IDLE;
        end
      end

      default: begin
        w_state_nxt = IDLE;
      end
    endcase
  end

  // FSM state register.
  always_ff @(posedge clk or negedge rst_n) begin
    // NOTE: clocked state uses non-blocking assignments so all registers update together.
    if (!rst_n) begin
      r_state <= IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  // Grant, pointer, beat counter and status registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_rr_ptr    <= '0;
      r_grant     <= '0;
      r_beat_cnt  <= '0;
      r_pkt_count <= '0;
      r_err_len   <= 1'b0;
      r_err_frame <= 1'b0;
    end else begin
      r_rr_ptr    <= w_rr_ptr_nxt;
      r_grant     <= w_grant_nxt;
      r_beat_cnt  <= w_beat_cnt_nxt;
      r_pkt_count <= w_pkt_count_nxt;
      r_err_len   <= w_err_len_nxt;
      r_err_frame <= w_err_frame_nxt;
    end
  end

  assign busy      = (r_state != IDLE);
  assign cur_grant = r_grant;
  assign pkt_count = r_pkt_count;
  assign err_len   = r_err_len;
  assign err_frame = r_err_frame;

endmodule

// File: tb/tb_tx_packet_arbiter.sv
// Randomized bench for tx_packet_arbiter. Per-port sources hold queues of
// packets; a transaction-level reference model decides ownership, readiness,
// truncation and status, and each cycle the DUT outputs are compared against it.
module tb_tx_packet_arbiter;
  import net_pkg::*;

  localparam int N    = 4;
  localparam int DW   = NET_DATA_WIDTH;
  localparam int MAXB = 4;
  localparam int IW   = $clog2(N);
  localparam int NCYC = 3000;

  logic              clk;
  logic              rst_n;
  logic [N-1:0]      port_en;
  logic [N-1:0]      s_valid;
  logic [N*DW-1:0]   s_data;
  logic [N-1:0]      s_sop;
  logic [N-1:0]      s_eop;
  logic [N-1:0]      s_ready;
  logic              m_valid;
  logic [DW-1:0]     m_data;
  logic              m_sop;
  logic              m_eop;
  logic              m_ready;
  logic              busy;
  logic [IW-1:0]     cur_grant;
  logic [15:0]       pkt_count;
  logic              err_len;
  logic              err_frame;

  tx_packet_arbiter #(
    .N_PORTS    (N),
    .DATA_WIDTH (DW),
    .MAX_BEATS  (MAXB)
  ) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .port_en   (port_en),
    .s_valid   (s_valid),
    .s_data    (s_data),
    .s_sop     (s_sop),
    .s_eop     (s_eop),
    .s_ready   (s_ready),
    .m_valid   (m_valid),
    .m_data    (m_data),
    .m_sop     (m_sop),
    .m_eop     (m_eop),
    .m_ready   (m_ready),
    .busy      (busy),
    .cur_grant (cur_grant),
    .pkt_count (pkt_count),
    .err_len   (err_len),
    .err_frame (err_frame)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    net_beat_t d;
    bit        sop;
    bit        eop;
  } beat_t;

  beat_t srcq [N][$];

  int n_tests = 0;
  int n_fail  = 0;
  int cyc     = 0;
  int pkt_id  = 0;

  // Reference model: who owns the interface, whether the rest of an
  // over-long packet is being thrown away, and the management status.
  int mo_owner;   // -1 when nobody holds the interface
  bit mo_drain;
  int mo_cnt;     // beats already forwarded in the current packet
  int mo_ptr;     // port searched first at the next arbitration
  int mo_last;    // last granted port (cur_grant)
  int mo_pkts;
  bit mo_elen;
  bit mo_eframe;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s @cycle %0d: got %0h expected %0h", tag, cyc, got, exp);
    end
  endtask

  task automatic model_reset();
    mo_owner  = -1;
    mo_drain  = 1'b0;
    mo_cnt    = 0;
    mo_ptr    = 0;
    mo_last   = 0;
    mo_pkts   = 0;
    mo_elen   = 1'b0;
    mo_eframe = 1'b0;
  endtask

  task automatic check_all_zero(input string tag);
    check({tag, ".m_valid"},   64'(m_valid),   64'd0);
    check({tag, ".m_data"},    64'(m_data),    64'd0);
    check({tag, ".m_sop"},     64'(m_sop),     64'd0);
    check({tag, ".m_eop"},     64'(m_eop),     64'd0);
    check({tag, ".s_ready"},   64'(s_ready),   64'd0);
    check({tag, ".busy"},      64'(busy),      64'd0);
    check({tag, ".cur_grant"}, 64'(cur_grant), 64'd0);
    check({tag, ".pkt_count"}, 64'(pkt_count), 64'd0);
    check({tag, ".err_len"},   64'(err_len),   64'd0);
    check({tag, ".err_frame"}, 64'(err_frame), 64'd0);
  endtask

  // Refill empty sources: mostly packets of 1..6 beats (some exceed MAXB),
  // occasionally a lone beat with no SOP.
  task automatic gen_traffic();
    for (int i = 0; i < N; i++) begin
      if (srcq[i].size() == 0 && $urandom_range(2) == 0) begin
        beat_t b;
        if ($urandom_range(15) == 0) begin
          b.d   = {8'(i), 24'(pkt_id), 32'hDEAD};
          b.sop = 1'b0;
          b.eop = 1'($urandom_range(1));
          srcq[i].push_back(b);
        end else begin
          int len;
          len = $urandom_range(1, 6);
          for (int k = 0; k < len; k++) begin
            b.d   = {8'(i), 24'(pkt_id), 32'(k)};
            b.sop = (k == 0);
            b.eop = (k == len - 1);
            srcq[i].push_back(b);
          end
        end
        pkt_id++;
      end
    end
  endtask

  task automatic drive_inputs();
    for (int i = 0; i < N; i++) begin
      port_en[i] = ($urandom_range(9) != 0);
      if (srcq[i].size() > 0) begin
        s_valid[i]            = ($urandom_range(3) != 0);
        s_data[i*DW +: DW]    = srcq[i][0].d;
        s_sop[i]              = srcq[i][0].sop;
        s_eop[i]              = srcq[i][0].eop;
      end else begin
        s_valid[i]            = 1'b0;
        s_data[i*DW +: DW]    = {$urandom, $urandom};
        s_sop[i]              = 1'($urandom_range(1));
        s_eop[i]              = 1'($urandom_range(1));
      end
    end
    m_ready = ($urandom_range(3) != 0);
  endtask

  // Compare this cycle's DUT outputs with the model, then advance the model
  // and the source queues by whatever the model says was accepted.
  task automatic check_and_step();
    logic [N-1:0] er;
    bit           ev;
    net_beat_t    ed;
    bit           esop;
    bit           eeop;
    int           o;

    er   = '0;
    ev   = 1'b0;
    ed   = '0;
    esop = 1'b0;
    eeop = 1'b0;
    o    = mo_owner;

    if (o < 0) begin
      for (int i = 0; i < N; i++) er[i] = port_en[i] && s_valid[i] && !s_sop[i];
    end else if (!mo_drain) begin
      ev    = s_valid[o];
      ed    = s_data[o*DW +: DW];
      esop  = s_sop[o];
      eeop  = s_eop[o] || (mo_cnt == MAXB - 1);
      er[o] = m_ready;
    end else begin
      er[o] = 1'b1;
    end

    check("m_valid",   64'(m_valid),   64'(ev));
    check("s_ready",   64'(s_ready),   64'(er));
    check("busy",      64'(busy),      64'(o >= 0));
    check("cur_grant", 64'(cur_grant), 64'(mo_last));
    check("pkt_count", 64'(pkt_count), 64'(mo_pkts));
    check("err_len",   64'(err_len),   64'(mo_elen));
    check("err_frame", 64'(err_frame), 64'(mo_eframe));
    if (ev) begin
      check("m_data", 64'(m_data), 64'(ed));
      check("m_sop",  64'(m_sop),  64'(esop));
      check("m_eop",  64'(m_eop),  64'(eeop));
    end

    if (o < 0) begin
      if (|er) mo_eframe = 1'b1;
      for (int k = 0; k < N; k++) begin
        int p;
        p = (mo_ptr + k) % N;
        if (port_en[p] && s_valid[p] && s_sop[p]) begin
          mo_owner = p;
          mo_last  = p;
          mo_cnt   = 0;
          break;
        end
      end
    end else if (!mo_drain) begin
      if (s_valid[o] && m_ready) begin
        if (s_eop[o]) begin
          mo_pkts  = (mo_pkts + 1) % 65536;
          mo_ptr   = (o + 1) % N;
          mo_owner = -1;
        end else if (mo_cnt == MAXB - 1) begin
          mo_pkts  = (mo_pkts + 1) % 65536;
          mo_elen  = 1'b1;
          mo_ptr   = (o + 1) % N;
          mo_drain = 1'b1;
        end
        mo_cnt++;
      end
    end else if (s_valid[o] && s_eop[o]) begin
      mo_owner = -1;
      mo_drain = 1'b0;
    end

    for (int i = 0; i < N; i++) begin
      if (er[i] && s_valid[i]) void'(srcq[i].pop_front());
    end
  endtask

  initial begin
    bit did_reset;
    did_reset = 1'b0;
    rst_n   = 1'b0;
    port_en = '0;
    s_valid = '0;
    s_data  = '0;
    s_sop   = '0;
    s_eop   = '0;
    m_ready = 1'b0;
    model_reset();

    #12;
    check_all_zero("reset");
    @(negedge clk);
    rst_n = 1'b1;

    for (cyc = 0; cyc < NCYC; cyc++) begin
      @(negedge clk);
      // Once past the midpoint, pull reset while a packet holds the grant.
      if (!did_reset && cyc >= NCYC/2 && mo_owner >= 0) begin
        did_reset = 1'b1;
        #2;
        s_valid = '0;
        rst_n   = 1'b0;
        #1;
        check_all_zero("async_reset");
        model_reset();
        @(posedge clk);
        #1;
        check_all_zero("held_reset");
        @(negedge clk);
        rst_n = 1'b1;
      end
      gen_traffic();
      drive_inputs();
      #1;
      check_and_step();
    end

    check("reset_exercised", 64'(did_reset), 64'd1);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
